// File: rtl/serial_shift_unit_pkg.sv
// Shared definitions for the serial shift/rotate engine: operation codes,
// FSM state codes, datapath widths and the per-cycle step-size helper.
package serial_shift_unit_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;

    // ALUFunc encoding, shared with the barrel shifter and ALU control
    typedef enum logic [1:0] {
        OP_ROTL = 2'b00,
        OP_SLL  = 2'b01,
        OP_SRL  = 2'b10,
        OP_SRA  = 2'b11
    } shift_op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_SHIFT = 2'b01,
        ST_DONE  = 2'b10
    } shift_state_e;

    // Bits to shift this cycle: STEP, clamped to what is left so rem never wraps
    function automatic logic [AMT_W-1:0] step_amount(input logic [AMT_W-1:0] rem,
                                                     input int step);
        logic [AMT_W-1:0] step_v;
        step_v = AMT_W'(step);
        return (rem < step_v) ? rem : step_v;
    endfunction

endpackage

// File: rtl/serial_shift_unit_shift_step.sv
// Combinational single step of the serial shifter: shifts/rotates a 32-bit
// word by a small amount k (0..STEP) according to the selected operation.
module serial_shift_unit_shift_step
    import serial_shift_unit_pkg::*;
(
    input  logic [DATA_W-1:0] i_x,
    input  shift_op_e         i_op,
    input  logic [AMT_W-1:0]  i_k,
    output logic [DATA_W-1:0] o_y
);

    logic [2*DATA_W-1:0] w_rot;

    // Select the shifted word; rotation takes the upper half of a doubled word
    always_comb begin
        w_rot = {i_x, i_x} << i_k;
        o_y   = i_x;
        case (i_op)
            OP_ROTL: o_y = w_rot[2*DATA_W-1:DATA_W];
            OP_SLL:  o_y = i_x << i_k;
            OP_SRL:  o_y = i_x >> i_k;
            OP_SRA:  o_y = $signed(i_x) >>> i_k;
            default: o_y = i_x;
        endcase
    end

endmodule

// File: rtl/serial_shift_unit.sv
// Multi-cycle shift/rotate engine. Accepts one request over a valid/ready
// handshake, shifts STEP bits per cycle, and presents the 32-bit result over
// a second valid/ready handshake. Flush aborts an operation in flight.
module serial_shift_unit
    import serial_shift_unit_pkg::*;
#(
    parameter int STEP = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [AMT_W-1:0]  in_amt,
    input  logic [1:0]        ALUFunc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data
);

    shift_state_e       r_state;
    shift_state_e       w_state_nxt;
    shift_op_e          r_op;
    logic [AMT_W-1:0]   r_rem;
    logic [DATA_W-1:0]  r_work;
    logic [DATA_W-1:0]  r_out;

    logic               w_accept;
    logic [AMT_W-1:0]   w_k;
    logic [DATA_W-1:0]  w_step;

    // A request is taken only in IDLE, and never on a flush edge
    assign w_accept = (r_state == ST_IDLE) && in_valid && !flush;
    assign w_k      = step_amount(r_rem, STEP);

    serial_shift_unit_shift_step u_step (
        .i_x  (r_work),
        .i_op (r_op),
        .i_k  (w_k),
        .o_y  (w_step)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic. Every request passes through SHIFT; when rem reaches
    // zero the following cycle moves the result into DONE, which gives the
    // 1 + ceil(amt/STEP) cycle latency including the amt==0 case.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                if (flush)              w_state_nxt = ST_IDLE;
                else if (r_rem == '0)   w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                if (flush || out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the current state
    always_comb begin
        in_ready  = (r_state == ST_IDLE);
        out_valid = (r_state == ST_DONE);
        out_data  = r_out;
    end

    // Working register, remaining-amount counter, latched op and result register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op   <= OP_ROTL;
            r_rem  <= '0;
            r_work <= '0;
            r_out  <= '0;
        end else if (w_accept) begin
            r_op   <= shift_op_e'(ALUFunc);
            r_rem  <= in_amt;
            r_work <= in_data;
        end else if ((r_state == ST_SHIFT) && !flush) begin
            if (r_rem != '0) begin
                r_work <= w_step;
                r_rem  <= r_rem - w_k;
            end else begin
                r_out  <= r_work;
            end
        end
    end

endmodule

// File: tb/tb_serial_shift_unit.sv
// Self-checking bench for serial_shift_unit: four instances (STEP 1/2/4/8)
// driven independently, compared against a bit-index reference model.
module tb_serial_shift_unit;

    localparam int NI = 4;

    logic        clk;
    logic        rst_n;
    logic        in_valid  [NI];
    logic        in_ready  [NI];
    logic [31:0] in_data   [NI];
    logic [4:0]  in_amt    [NI];
    logic [1:0]  alu       [NI];
    logic        flush     [NI];
    logic        out_valid [NI];
    logic        out_ready [NI];
    logic [31:0] out_data  [NI];

    int vectors;
    int miscompares;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int ST = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 8;
        serial_shift_unit #(.STEP(ST)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .in_data   (in_data[g]),
            .in_amt    (in_amt[g]),
            .ALUFunc   (alu[g]),
            .flush     (flush[g]),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .out_data  (out_data[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int step_of(input int i);
        case (i)
            0:       return 1;
            1:       return 2;
            2:       return 4;
            default: return 8;
        endcase
    endfunction

    // One-shot result, defined bit by bit from where each output bit comes from
    function automatic logic [31:0] model(input logic [31:0] d, input int a, input int op);
        logic [31:0] r;
        for (int b = 0; b < 32; b++) begin
            case (op)
                0: r[b] = d[(b - a + 32) % 32];
                1: r[b] = (b >= a) ? d[b - a] : 1'b0;
                2: r[b] = (b + a < 32) ? d[b + a] : 1'b0;
                default: r[b] = (b + a < 32) ? d[b + a] : d[31];
            endcase
        end
        return r;
    endfunction

    function automatic int exp_lat(input int i, input int a);
        return 1 + (a + step_of(i) - 1) / step_of(i);
    endfunction

    // Drive one request, scramble inputs after accept, wait for the result,
    // hold it for 'stall' cycles, then drain it. Returns observations only.
    task automatic drive_req(input int i, input logic [31:0] d, input logic [4:0] a,
                             input logic [1:0] op, input int stall,
                             output logic acc_rdy, output int lat, output logic [31:0] res,
                             output logic hold_ok, output logic drain_ok);
        @(negedge clk);
        acc_rdy     = in_ready[i];
        in_data[i]  = d;
        in_amt[i]   = a;
        alu[i]      = op;
        in_valid[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[i] = 1'b0;
        in_data[i]  = $urandom;
        in_amt[i]   = 5'($urandom);
        alu[i]      = 2'($urandom);
        lat = 0;
        while (out_valid[i] !== 1'b1 && lat < 100) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        res = out_data[i];
        hold_ok = 1'b1;
        repeat (stall) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid[i] !== 1'b1 || out_data[i] !== res || in_ready[i] !== 1'b0)
                hold_ok = 1'b0;
        end
        out_ready[i] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready[i] = 1'b0;
        drain_ok = (out_valid[i] === 1'b0) && (in_ready[i] === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            vectors++;
            if (in_ready[i] !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_in_ready[%0d] got %b want 1", i, in_ready[i]);
            end
            vectors++;
            if (out_valid[i] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_out_valid[%0d] got %b want 0", i, out_valid[i]);
            end
            vectors++;
            if (out_data[i] !== 32'h0) begin
                miscompares++;
                $display("FAIL reset_out_data[%0d] got %h want 0", i, out_data[i]);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic acc; int lat; logic [31:0] res; logic hok, dok;
        // STEP=1 SLL by 31
        drive_req(0, 32'h0000_0001, 5'd31, 2'b01, 0, acc, lat, res, hok, dok);
        vectors++;
        if (res !== 32'h8000_0000) begin
            miscompares++; $display("FAIL sll31_data got %h want 80000000", res);
        end
        vectors++;
        if (lat != 32) begin
            miscompares++; $display("FAIL sll31_latency got %0d want 32", lat);
        end
        // STEP=4 SRA / SRL by 4
        drive_req(2, 32'h8000_0000, 5'd4, 2'b11, 0, acc, lat, res, hok, dok);
        vectors++;
        if (res !== 32'hF800_0000 || lat != 2) begin
            miscompares++; $display("FAIL sra4 got %h lat %0d want f8000000 lat 2", res, lat);
        end
        drive_req(2, 32'h8000_0000, 5'd4, 2'b10, 0, acc, lat, res, hok, dok);
        vectors++;
        if (res !== 32'h0800_0000 || lat != 2) begin
            miscompares++; $display("FAIL srl4 got %h lat %0d want 08000000 lat 2", res, lat);
        end
        // Rotates
        drive_req(0, 32'h8000_0001, 5'd1, 2'b00, 0, acc, lat, res, hok, dok);
        vectors++;
        if (res !== 32'h0000_0003 || lat != 2) begin
            miscompares++; $display("FAIL rotl1 got %h lat %0d want 00000003 lat 2", res, lat);
        end
        for (int op = 0; op < 4; op++) begin
            drive_req(3, 32'h1234_5678, 5'd0, 2'(op), 0, acc, lat, res, hok, dok);
            vectors++;
            if (res !== 32'h1234_5678 || lat != 1) begin
                miscompares++;
                $display("FAIL amt0_op%0d got %h lat %0d want 12345678 lat 1", op, res, lat);
            end
        end
    endtask

    task automatic test_backpressure();
        logic acc; int lat; logic [31:0] res; logic hok, dok;
        drive_req(1, 32'hCAFE_F00D, 5'd7, 2'b00, 10, acc, lat, res, hok, dok);
        vectors++;
        if (res !== model(32'hCAFE_F00D, 7, 0)) begin
            miscompares++; $display("FAIL bp_data got %h want %h", res, model(32'hCAFE_F00D, 7, 0));
        end
        vectors++;
        if (hok !== 1'b1) begin
            miscompares++; $display("FAIL bp_hold got %b want 1", hok);
        end
        vectors++;
        if (dok !== 1'b1) begin
            miscompares++; $display("FAIL bp_drain got %b want 1", dok);
        end
        drive_req(1, 32'h0000_00F0, 5'd4, 2'b10, 0, acc, lat, res, hok, dok);
        vectors++;
        if (acc !== 1'b1 || res !== 32'h0000_000F) begin
            miscompares++; $display("FAIL bp_next got rdy %b data %h want rdy 1 data 0000000f", acc, res);
        end
    endtask

    task automatic test_flush();
        logic seen;
        @(negedge clk);
        in_data[0] = 32'h0000_0001; in_amt[0] = 5'd31; alu[0] = 2'b01; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        flush[0] = 1'b0;
        vectors++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_idle got rdy %b vld %b want rdy 1 vld 0", in_ready[0], out_valid[0]);
        end
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); @(negedge clk);
            if (out_valid[0] === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL flush_no_result got %b want 0", seen);
        end
        // Flush in IDLE blocks a same-edge request
        in_data[0] = 32'h1; in_amt[0] = 5'd0; alu[0] = 2'b00;
        in_valid[0] = 1'b1; flush[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0; flush[0] = 1'b0;
        seen = ~in_ready[0];
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            if (out_valid[0] === 1'b1) seen = 1'b1;
        end
        vectors++;
        if (seen !== 1'b0) begin
            miscompares++; $display("FAIL flush_blocks_accept got %b want 0", seen);
        end
    endtask

    task automatic test_reset_mid();
        logic acc; int lat; logic [31:0] res; logic hok, dok;
        drive_req(0, 32'h0000_00A5, 5'd3, 2'b01, 0, acc, lat, res, hok, dok);
        @(negedge clk);
        in_data[0] = 32'h0000_0001; in_amt[0] = 5'd31; alu[0] = 2'b01; in_valid[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid[0] = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        vectors++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || out_data[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mid got rdy %b vld %b data %h want 1 0 00000000",
                     in_ready[0], out_valid[0], out_data[0]);
        end
    endtask

    task automatic test_random();
        logic acc; int lat; logic [31:0] res; logic hok, dok;
        logic [31:0] d; int a; int op; int idx;
        for (int s = 0; s < 3; s++) begin
            idx = (s == 2) ? 3 : s;
            for (int n = 0; n < 40; n++) begin
                d  = $urandom;
                a  = $urandom_range(0, 31);
                op = $urandom_range(0, 3);
                drive_req(idx, d, 5'(a), 2'(op), $urandom_range(0, 3), acc, lat, res, hok, dok);
                vectors++;
                if (res !== model(d, a, op)) begin
                    miscompares++;
                    $display("FAIL rand_data step%0d op%0d d=%h amt=%0d got %h want %h",
                             step_of(idx), op, d, a, res, model(d, a, op));
                end
                vectors++;
                if (lat != exp_lat(idx, a)) begin
                    miscompares++;
                    $display("FAIL rand_latency step%0d amt=%0d got %0d want %0d",
                             step_of(idx), a, lat, exp_lat(idx, a));
                end
                vectors++;
                if (acc !== 1'b1 || hok !== 1'b1 || dok !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rand_handshake step%0d got rdy %b hold %b drain %b want 1 1 1",
                             step_of(idx), acc, hok, dok);
                end
            end
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        for (int i = 0; i < NI; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            in_amt[i]    = '0;
            alu[i]       = '0;
            flush[i]     = 1'b0;
            out_ready[i] = 1'b0;
        end
        test_reset();
        test_directed();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
